// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned CAUSE_W = 2;

    // Next-PC select; codes 6 and 7 are unused and fall back to sequential.
    typedef enum logic [OP_W-1:0] {
        OpSeq    = 3'd0,
        OpBranch = 3'd1,
        OpJump   = 3'd2,
        OpCall   = 3'd3,
        OpRet    = 3'd4,
        OpEret   = 3'd5
    } pc_op_t;

    typedef enum logic [CAUSE_W-1:0] {
        CauseNone     = 2'd0,
        CauseExt      = 2'd1,
        CauseMisalign = 2'd2,
        CauseRasUflow = 2'd3
    } trap_cause_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push on full overwrites the oldest entry,
// pop on empty is ignored.
module pc_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [XLEN-1:0]                  push_data,
    output logic [XLEN-1:0]                  top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
    output logic                             empty,
    output logic                             full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_LAST : p - 1'b1;
    endfunction

    // wr_q points at the next free slot; the top of stack sits just below it.
    assign top   = mem[ptr_dec(wr_q)];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);

    // Pointer and occupancy update.
    always_comb begin
        wr_d    = wr_q;
        count_d = count_q;
        if (push) begin
            wr_d = ptr_inc(wr_q);
            if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        end else if (pop && (count_q != '0)) begin
            wr_d    = ptr_dec(wr_q);
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= push_data;
    end

    // The owner never pushes and pops in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && pop)) else $error("pc_ras: simultaneous push and pop");
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, alignment check, traps, EPC and RAS.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INC          = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic [OP_W-1:0]                op,
    input  logic [XLEN-1:0]                target,
    input  logic [XLEN-1:0]                offset,
    input  logic                           trap_req,
    output logic [XLEN-1:0]                pc_q,
    output logic [XLEN-1:0]                epc_q,
    output logic                           trap_taken,
    output logic [CAUSE_W-1:0]             trap_cause,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_empty,
    output logic                           ras_full
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

    logic [XLEN-1:0] pc_d, epc_d, cand, ras_top;
    logic            taken_q, taken_d, check_align, push, pop;
    trap_cause_t     cause_q, cause_d, fault;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + INC_W),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign trap_taken = taken_q;
    assign trap_cause = cause_q;

    // Next-PC selection and trap resolution; a trap overrides any PC chosen below.
    always_comb begin
        pc_d        = pc_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        taken_d     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        cand        = '0;
        check_align = 1'b0;
        fault       = CauseNone;

        if (trap_req) begin
            fault = CauseExt;
        end else if (!stall) begin
            case (op)
                OpBranch: begin
                    cand        = pc_q + offset;
                    check_align = 1'b1;
                end
                OpJump: begin
                    cand        = target;
                    check_align = 1'b1;
                end
                OpCall: begin
                    cand        = target;
                    check_align = 1'b1;
                    push        = ((target & ALIGN_MASK) == '0);
                end
                OpRet: begin
                    if (ras_empty) begin
                        fault = CauseRasUflow;
                    end else begin
                        // A misaligned return address still consumes its entry.
                        pop         = 1'b1;
                        cand        = ras_top;
                        check_align = 1'b1;
                    end
                end
                OpEret:  pc_d = epc_q;
                default: pc_d = pc_q + INC_W;
            endcase

            if (check_align) begin
                if ((cand & ALIGN_MASK) != '0) fault = CauseMisalign;
                else                           pc_d  = cand;
            end
        end

        if (fault != CauseNone) begin
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
            taken_d = 1'b1;
            cause_d = fault;
        end
    end

    // Architectural PC, EPC and trap status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            taken_q <= 1'b0;
            cause_q <= CauseNone;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            taken_q <= taken_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed plan steps plus random ops against a queue model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, trap_req;
    logic [2:0]  op;
    logic [31:0] target, offset;
    logic [31:0] pc_q, epc_q;
    logic        trap_taken, ras_empty, ras_full;
    logic [1:0]  trap_cause;
    logic [2:0]  ras_count;

    int tests = 0;
    int fails = 0;

    // Reference model state; the RAS is a plain queue, newest entry at the back.
    logic [31:0] m_pc, m_epc;
    logic        m_taken;
    logic [1:0]  m_cause;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN         (32),
        .INC          (4),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .op         (op),
        .target     (target),
        .offset     (offset),
        .trap_req   (trap_req),
        .pc_q       (pc_q),
        .epc_q      (epc_q),
        .trap_taken (trap_taken),
        .trap_cause (trap_cause),
        .ras_count  (ras_count),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_trap(input logic [1:0] c);
        m_epc   = m_pc;
        m_pc    = 32'h100;
        m_taken = 1'b1;
        m_cause = c;
    endtask

    task automatic m_goto(input logic [31:0] a);
        if (a[1:0] != 2'b00) m_trap(2'd2);
        else                 m_pc = a;
    endtask

    task automatic model_step(input logic r, input logic s, input logic [2:0] o,
                              input logic [31:0] t, input logic [31:0] f, input logic q);
        logic [31:0] ret;
        if (r) begin
            m_pc = 32'h0; m_epc = 32'h0; m_taken = 1'b0; m_cause = 2'd0;
            m_ras.delete();
            return;
        end
        m_taken = 1'b0;
        if (q) begin
            m_trap(2'd1);
        end else if (!s) begin
            case (o)
                3'd1: m_goto(m_pc + f);
                3'd2: m_goto(t);
                3'd3: begin
                    if (t[1:0] != 2'b00) begin
                        m_trap(2'd2);
                    end else begin
                        if (m_ras.size() == 4) void'(m_ras.pop_front());
                        m_ras.push_back(m_pc + 32'd4);
                        m_pc = t;
                    end
                end
                3'd4: begin
                    if (m_ras.size() == 0) begin
                        m_trap(2'd3);
                    end else begin
                        ret = m_ras.pop_back();
                        m_goto(ret);
                    end
                end
                3'd5:    m_pc = m_epc;
                default: m_pc = m_pc + 32'd4;
            endcase
        end
    endtask

    // Drive one cycle, advance the model, then compare every output after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic [2:0] o,
                        input logic [31:0] t, input logic [31:0] f, input logic q);
        rst = r; stall = s; op = o; target = t; offset = f; trap_req = q;
        model_step(r, s, o, t, f, q);
        @(posedge clk);
        #1;
        chk({tag, ".pc"},    pc_q,              m_pc);
        chk({tag, ".epc"},   epc_q,             m_epc);
        chk({tag, ".taken"}, 32'(trap_taken),   32'(m_taken));
        chk({tag, ".cause"}, 32'(trap_cause),   32'(m_cause));
        chk({tag, ".count"}, 32'(ras_count),    32'(m_ras.size()));
        chk({tag, ".empty"}, 32'(ras_empty),    32'(m_ras.size() == 0));
        chk({tag, ".full"},  32'(ras_full),     32'(m_ras.size() == 4));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; op = 3'd0; target = '0; offset = '0; trap_req = 1'b0;

        // Reset, sequential run and stall hold.
        step("rst", 1, 0, 0, 0, 0, 0);
        chk("rst.pc_const", pc_q, 32'h0);
        chk("rst.empty_const", 32'(ras_empty), 32'd1);
        step("seq1", 0, 0, 0, 0, 0, 0); chk("seq1.pc_const", pc_q, 32'h4);
        step("seq2", 0, 0, 0, 0, 0, 0); chk("seq2.pc_const", pc_q, 32'h8);
        step("seq3", 0, 0, 0, 0, 0, 0); chk("seq3.pc_const", pc_q, 32'hC);
        step("stl1", 0, 1, 0, 0, 0, 0); chk("stl1.pc_const", pc_q, 32'hC);
        step("stl2", 0, 1, 2, 32'h80, 0, 0); chk("stl2.pc_const", pc_q, 32'hC);

        // Jump, negative branch, wrap at top of address space.
        step("jmp", 0, 0, 2, 32'h64, 0, 0);         chk("jmp.pc_const", pc_q, 32'h64);
        step("br",  0, 0, 1, 0, 32'hFFFF_FFF8, 0);  chk("br.pc_const", pc_q, 32'h5C);
        step("jtop", 0, 0, 2, 32'hFFFF_FFFC, 0, 0); chk("jtop.pc_const", pc_q, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 0, 0, 0, 0);             chk("wrap.pc_const", pc_q, 32'h0);

        // Single call/return.
        step("j10", 0, 0, 2, 32'h10, 0, 0);
        step("call", 0, 0, 3, 32'h200, 0, 0);
        chk("call.pc_const", pc_q, 32'h200);
        chk("call.count_const", 32'(ras_count), 32'd1);
        step("ret", 0, 0, 4, 0, 0, 0);
        chk("ret.pc_const", pc_q, 32'h14);
        chk("ret.empty_const", 32'(ras_empty), 32'd1);

        // Overflow the stack, then drain it past empty.
        for (int i = 0; i < 5; i++) step("calln", 0, 0, 3, 32'h200 + 32'h100 * i, 0, 0);
        chk("calln.full_const", 32'(ras_full), 32'd1);
        chk("calln.count_const", 32'(ras_count), 32'd4);
        step("ret1", 0, 0, 4, 0, 0, 0); chk("ret1.pc_const", pc_q, 32'h504);
        step("ret2", 0, 0, 4, 0, 0, 0); chk("ret2.pc_const", pc_q, 32'h404);
        step("ret3", 0, 0, 4, 0, 0, 0); chk("ret3.pc_const", pc_q, 32'h304);
        step("ret4", 0, 0, 4, 0, 0, 0); chk("ret4.pc_const", pc_q, 32'h204);
        step("ret5", 0, 0, 4, 0, 0, 0);
        chk("ret5.pc_const", pc_q, 32'h100);
        chk("ret5.cause_const", 32'(trap_cause), 32'd3);
        chk("ret5.taken_const", 32'(trap_taken), 32'd1);
        chk("ret5.epc_const", epc_q, 32'h204);
        step("after", 0, 0, 0, 0, 0, 0);
        chk("after.taken_const", 32'(trap_taken), 32'd0);

        // Misaligned jump and trap return.
        step("j40", 0, 0, 2, 32'h40, 0, 0);
        step("mis", 0, 0, 2, 32'h66, 0, 0);
        chk("mis.pc_const", pc_q, 32'h100);
        chk("mis.epc_const", epc_q, 32'h40);
        chk("mis.cause_const", 32'(trap_cause), 32'd2);
        step("eret", 0, 0, 5, 0, 0, 0);
        chk("eret.pc_const", pc_q, 32'h40);

        // External trap overrides stall and a pending call.
        step("c80", 0, 0, 3, 32'h80, 0, 0);
        step("ca0", 0, 0, 3, 32'hA0, 0, 0);
        step("ext", 0, 1, 3, 32'h200, 0, 1);
        chk("ext.pc_const", pc_q, 32'h100);
        chk("ext.cause_const", 32'(trap_cause), 32'd1);
        chk("ext.count_const", 32'(ras_count), 32'd2);

        // Reset with a full stack.
        step("c300", 0, 0, 3, 32'h300, 0, 0);
        step("c400", 0, 0, 3, 32'h400, 0, 0);
        chk("c400.full_const", 32'(ras_full), 32'd1);
        step("rst2", 1, 0, 3, 32'h500, 0, 1);
        chk("rst2.pc_const", pc_q, 32'h0);
        chk("rst2.count_const", 32'(ras_count), 32'd0);
        chk("rst2.cause_const", 32'(trap_cause), 32'd0);

        // Random operation mix against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t, f;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            f = 32'($urandom_range(0, 255)) - 32'd128;
            f[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                 3'($urandom_range(0, 7)), t, f, $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit. Successor to the fixed 32-bit load-only PC register.
- Holds the architectural PC and computes the next PC internally from an opcode: sequential, relative branch, absolute jump, call/return, trap and trap-return.
- Contains a circular return-address stack (RAS) and an exception PC (EPC) register. Sits between fetch and branch-resolution logic.

Parameters:
- XLEN, 32, PC/address width in bits.
- INC, 4, sequential increment in bytes; power of two; also defines the alignment requirement.
- RESET_VECTOR, 32'h0000_0000, pc_q value after reset.
- TRAP_VECTOR, 32'h0000_0100, pc_q value after any trap.
- RAS_DEPTH, 4, return-address stack entries; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS; op is ignored while high.
- op  in  3  next-PC select: SEQ=0, BRANCH=1, JUMP=2, CALL=3, RET=4, ERET=5; codes 6 and 7 behave as SEQ.
- target  in  XLEN  absolute target for JUMP and CALL.
- offset  in  XLEN  two's-complement byte offset for BRANCH.
- trap_req  in  1  external trap request.
- pc_q  out  XLEN  current PC, registered.
- epc_q  out  XLEN  saved exception PC, registered.
- trap_taken  out  1  one-cycle registered pulse when a trap is taken.
- trap_cause  out  2  cause code: 0 none, 1 external, 2 misaligned target, 3 RAS underflow. Held until the next trap or reset.
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_empty  out  1  asserted when ras_count==0.
- ras_full  out  1  asserted when ras_count==RAS_DEPTH.

Behaviour:
- Reset (sync, highest priority): pc_q=RESET_VECTOR, epc_q=0, trap_taken=0, trap_cause=0, ras_count=0, ras_empty=1, ras_full=0. RAS contents are don't-care. Reset mid-operation discards all RAS entries.
- Latency: inputs are sampled at edge N; pc_q reflects the result after edge N. No combinational input-to-output path.
- Priority per cycle: rst > trap_req > internal fault (misaligned, underflow) > stall > op.
- SEQ: pc_q <= pc_q + INC, modulo 2^XLEN (all-ones region wraps to 0).
- BRANCH: candidate = pc_q + offset, modulo 2^XLEN.
- JUMP: candidate = target.
- CALL: candidate = target; push pc_q+INC onto the RAS.
- CALL when full: overwrite the oldest entry (circular); ras_count stays RAS_DEPTH.
- RET: candidate = top of RAS; pop.
- RET when empty: underflow trap, cause 3; no pop.
- ERET: pc_q <= epc_q. No alignment check is applied.
- Alignment: if candidate[$clog2(INC)-1:0] != 0, take a misaligned trap (cause 2). A faulting CALL does not push; a faulting RET still pops.
- Trap taken (any cause):
  - pc_q <= TRAP_VECTOR; epc_q <= pc_q (PC of the instruction being redirected).
  - trap_taken=1 for exactly one cycle; trap_cause is updated.
  - No RAS change except the faulting-RET pop noted above.
- trap_req overrides stall and op. An op presented in the same cycle is discarded, with no push or pop.
- stall with no trap: pc_q, epc_q and RAS are unchanged; trap_taken=0.
- ras_count, ras_empty and ras_full are registered and consistent with RAS state after every edge.

Decomposition:
- Package pc_pkg:
  - pc_op_t enum (SEQ, BRANCH, JUMP, CALL, RET, ERET).
  - trap_cause_t enum (NONE, EXT, MISALIGN, RAS_UFLOW).
  - Cause-code width constant.
- Sub-module pc_ras:
  - Circular stack, parametrised by XLEN and RAS_DEPTH.
  - Ports: clk, rst, push, pop, push_data, top, count, empty, full.
  - Push-on-full overwrites the oldest entry; pop-on-empty is ignored.
  - Simultaneous push and pop are never issued by pc_unit; pc_ras asserts on it in simulation.
- pc_unit holds next-PC muxing, alignment check, trap logic and the EPC.

Test Plan (XLEN=32, INC=4, RESET_VECTOR=0, TRAP_VECTOR=0x100, RAS_DEPTH=4):
- Reset, then 3 cycles of SEQ, then 2 cycles of stall=1 -> pc_q 0x0, 0x4, 0x8, 0xC, then holds 0xC for 2 cycles; trap_taken stays 0.
- JUMP target=0x64, then BRANCH offset=0xFFFFFFF8, then JUMP target=0xFFFFFFFC, then SEQ -> pc_q 0x64, 0x5C, 0xFFFFFFFC, 0x0 (wrap).
- At pc_q=0x10: CALL target=0x200, then RET -> pc_q 0x200 with ras_count=1; then pc_q 0x14 with ras_empty=1.
- Five CALLs with targets 0x200, 0x300, 0x400, 0x500, 0x600, then five RETs:
  - After the calls: ras_full=1, ras_count=4.
  - RETs 1-4 land on the return addresses of calls 5, 4, 3, 2 in that order.
  - RET 5 -> pc_q=0x100, trap_cause=3, trap_taken pulses once, epc_q = PC at that RET.
- At pc_q=0x40: JUMP target=0x66 -> pc_q=0x100, epc_q=0x40, trap_cause=2. Then ERET -> pc_q=0x40.
- trap_req=1 together with stall=1 and CALL, with ras_count=2 -> pc_q=0x100, trap_cause=1, ras_count stays 2.
- Assert rst for one cycle with a full RAS -> pc_q=0, ras_count=0, ras_empty=1, trap_cause=0.
